exp_diff_serial: RTL

//  Bit-serial subtractor: computes |a - b| and the borrow/compare flag for two

---
 rtl/exp_diff_serial.sv | 107 ++++++++++
 1 files changed

// File: rtl/exp_diff_serial.sv
// Bit-serial |a - b| with borrow/equality flags, LSB first, one op in flight.
// Feeds the FP add/sub alignment path with the exponent difference and the larger side.
module exp_diff_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             a_lt_b,
  output logic             zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SUB  = 2'd1;
  localparam logic [1:0] NEG  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh, b_sh, r;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic             x, y, sub_bit, sub_brw, neg_bit, neg_cry;
  logic [WIDTH-1:0] r_sub, r_neg;

  // brw doubles as the +1 carry while negating
  always_comb begin
    x       = a_sh[0];
    y       = b_sh[0];
    sub_bit = x ^ y ^ brw;
    sub_brw = (~x & y) | (~(x ^ y) & brw);
    neg_bit = ~r[0] ^ brw;
    neg_cry = ~r[0] & brw;
    r_sub   = {sub_bit, r[WIDTH-1:1]};
    r_neg   = {neg_bit, r[WIDTH-1:1]};
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r      <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      a_lt_b <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh  <= a;
          b_sh  <= b;
          brw   <= 1'b0;
          cnt   <= '0;
          state <= SUB;
        end
        SUB: begin
          // one extra cycle after the last bit to resolve the final borrow
          if (cnt == CNT_END) begin
            a_lt_b <= brw;
            cnt    <= '0;
            if (brw) begin
              brw   <= 1'b1;
              state <= NEG;
            end else begin
              diff  <= r;
              zero  <= (r == '0);
              state <= DONE;
            end
          end else begin
            r    <= r_sub;
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            brw  <= sub_brw;
            cnt  <= cnt + CW'(1);
          end
        end
        NEG: begin
          r   <= r_neg;
          brw <= neg_cry;
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            diff  <= r_neg;
            zero  <= (r_neg == '0);
            state <= DONE;
          end
        end
        default: if (out_ready) state <= IDLE;
      endcase
    end
  end

endmodule
